// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the multi-cycle integer divider.
// Imported by the divider and by anything that decodes its handshake.
package div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef logic [63:0] double_reg_bus_t;

endpackage

// File: rtl/div.sv
// Restoring integer divider for DIV/DIVU: one quotient bit per cycle, MSB first.
// Returns {remainder, quotient} with a ready flag held until the requester drops start.
module div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);
    localparam logic [2*WIDTH-1:0] ZeroResult =
        (2*WIDTH)'(double_reg_bus_t'({ZeroWord, ZeroWord}));

    div_state_e         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH:0]     partial, diff;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        partial = {rem_q, quo_q[WIDTH-1]};
        // rem_q < divisor keeps partial below 2*divisor, so bit WIDTH is a valid sign.
        diff    = partial - {1'b0, dvs_q};
        quo_fix = neg_quo_q ? -quo_q : quo_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        unique case (state_q)
            DivFree: begin
                result_d = ZeroResult;
                if (start_i == DivStart && !annul_i) begin
                    dvs_d     = op2_abs;
                    quo_d     = op1_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
                    state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                result_d = ZeroResult;
                state_d  = DivEnd;
            end
            DivOn: begin
                if (annul_i || start_i == DivStop) begin
                    state_d  = DivFree;
                    cnt_d    = '0;
                    result_d = ZeroResult;
                end else if (cnt_q == LastCnt) begin
                    result_d = {rem_fix, quo_fix};
                    state_d  = DivEnd;
                end else begin
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = partial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    state_d  = DivFree;
                    cnt_d    = '0;
                    result_d = ZeroResult;
                end
            end
        endcase
    end

    always_comb begin
        ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
        result_o = result_q;
    end

endmodule
